// File: rtl/sd_spi_router_if.sv
// SPI bundle between the core, the virtual SD card and the physical SD card.
// The router sits in the middle: it owns the card-side outputs and core MISO.
// slave: router view. master: view of whatever drives the core side and models the cards.
interface sd_spi_router_if;
    // core side
    logic sdss;
    logic sdclk;
    logic sdmosi;
    logic sdmiso;
    // virtual card
    logic vsd_ss;
    logic vsd_sck;
    logic vsd_mosi;
    logic vsd_miso;
    // physical card
    logic SD_CS;
    logic SD_SCK;
    logic SD_MOSI;
    logic SD_MISO;

    modport slave (
        input  sdss, sdclk, sdmosi, vsd_miso, SD_MISO,
        output sdmiso, vsd_ss, vsd_sck, vsd_mosi, SD_CS, SD_SCK, SD_MOSI
    );

    modport master (
        output sdss, sdclk, sdmosi, vsd_miso, SD_MISO,
        input  sdmiso, vsd_ss, vsd_sck, vsd_mosi, SD_CS, SD_SCK, SD_MOSI
    );
endinterface

// File: rtl/sd_spi_router.sv
// Routes the core SPI bus to the virtual or physical SD card; switches only after the bus has been idle.
// Latency: SPI routing is combinational (zero cycles); a route change takes IDLE_CYCLES idle cycles plus one SWITCH cycle.
// Backpressure: none on SPI; a pending change waits for IDLE_CYCLES of sdss high, busy flags it.
// Ports: clk_sys/reset (sync, active high); img_mounted/img_size mount events; spi bundle;
//        vsd_sel current route (1 = virtual); busy change pending; drive_led activity indicator.
module sd_spi_router #(
    parameter int IDLE_CYCLES = 64,
    parameter int LED_HOLD    = 1048576
) (
    input  logic               clk_sys,
    input  logic               reset,
    input  logic               img_mounted,
    input  logic [31:0]        img_size,
    sd_spi_router_if.slave     spi,
    output logic               vsd_sel,
    output logic               busy,
    output logic               drive_led
);

    localparam int IW = $clog2(IDLE_CYCLES + 1);
    localparam int HW = $clog2(LED_HOLD + 1);

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        WAIT_IDLE = 2'd1,
        SWITCH    = 2'd2
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic          pend;
    logic          pend_nxt;
    logic          pend_sel;
    logic          vsd_sel_nxt;
    logic [IW-1:0] idle_cnt;
    logic [HW-1:0] hold_cnt;
    logic          idle_ok;

    assign idle_ok = (idle_cnt == IW'(IDLE_CYCLES));

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state    <= RUN;
            pend     <= 1'b0;
            pend_sel <= 1'b0;
            vsd_sel  <= 1'b0;
        end else begin
            state   <= state_nxt;
            pend    <= pend_nxt;
            vsd_sel <= vsd_sel_nxt;
            if (img_mounted) begin
                pend_sel <= (img_size != 32'd0);
            end
        end
    end

    always_comb begin
        state_nxt   = state;
        pend_nxt    = pend;
        vsd_sel_nxt = vsd_sel;
        case (state)
            RUN: begin
                if (pend) begin
                    if (pend_sel == vsd_sel) begin
                        pend_nxt = 1'b0;
                    end else begin
                        state_nxt = WAIT_IDLE;
                    end
                end
            end
            WAIT_IDLE: begin
                // A later event may have restored the current route: drop the change.
                if (pend_sel == vsd_sel) begin
                    state_nxt = RUN;
                    pend_nxt  = 1'b0;
                end else if (idle_ok && spi.sdss) begin
                    state_nxt = SWITCH;
                end
            end
            SWITCH: begin
                vsd_sel_nxt = pend_sel;
                pend_nxt    = 1'b0;
                state_nxt   = RUN;
            end
            default: state_nxt = RUN;
        endcase
        // A mount event always leaves a request behind for RUN to evaluate,
        // including one that lands in the SWITCH cycle itself.
        if (img_mounted) begin
            pend_nxt = 1'b1;
        end
    end

    // Idle counter: saturating count of consecutive deselected cycles.
    always_ff @(posedge clk_sys) begin
        if (reset || !spi.sdss) begin
            idle_cnt <= '0;
        end else if (!idle_ok) begin
            idle_cnt <= idle_cnt + IW'(1);
        end
    end

    // LED hold counter: reloads on every selected cycle, drains to zero otherwise.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            hold_cnt <= '0;
        end else if (!spi.sdss) begin
            hold_cnt <= HW'(LED_HOLD);
        end else if (hold_cnt != '0) begin
            hold_cnt <= hold_cnt - HW'(1);
        end
    end

    assign drive_led = !reset && (!spi.sdss || (hold_cnt != '0));
    assign busy      = pend || (state != RUN);

    // Unselected card (and both cards in SWITCH) parked: CS high, SCK low, MOSI high.
    always_comb begin
        spi.vsd_ss   = 1'b1;
        spi.vsd_sck  = 1'b0;
        spi.vsd_mosi = 1'b1;
        spi.SD_CS    = 1'b1;
        spi.SD_SCK   = 1'b0;
        spi.SD_MOSI  = 1'b1;
        spi.sdmiso   = 1'b1;
        if (state != SWITCH) begin
            if (vsd_sel) begin
                spi.vsd_ss   = spi.sdss;
                spi.vsd_sck  = spi.sdclk;
                spi.vsd_mosi = spi.sdmosi;
                spi.sdmiso   = spi.vsd_miso;
            end else begin
                spi.SD_CS    = spi.sdss;
                spi.SD_SCK   = spi.sdclk;
                spi.SD_MOSI  = spi.sdmosi;
                spi.sdmiso   = spi.SD_MISO;
            end
        end
    end

endmodule

// File: tb/tb_sd_spi_router.sv
module tb_sd_spi_router;

    logic        clk = 1'b0;
    logic        reset;
    logic        img_mounted;
    logic [31:0] img_size;
    logic        vsd_sel;
    logic        busy;
    logic        drive_led;

    int checks   = 0;
    int failures = 0;

    sd_spi_router_if spi ();

    sd_spi_router #(.IDLE_CYCLES(64), .LED_HOLD(16)) dut (
        .clk_sys     (clk),
        .reset       (reset),
        .img_mounted (img_mounted),
        .img_size    (img_size),
        .spi         (spi),
        .vsd_sel     (vsd_sel),
        .busy        (busy),
        .drive_led   (drive_led)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset        = 1'b1;
        img_mounted  = 1'b0;
        img_size     = 32'd0;
        spi.sdss     = 1'b1;
        spi.sdclk    = 1'b1;
        spi.sdmosi   = 1'b0;
        spi.vsd_miso = 1'b0;
        spi.SD_MISO  = 1'b0;

        // Reset state: physical route follows the core, virtual card parked.
        tick(2);
        chk("rst_busy", busy, 0);
        chk("rst_vsd_sel", vsd_sel, 0);
        chk("rst_led", drive_led, 0);
        chk("rst_sd_sck", spi.SD_SCK, 1);
        chk("rst_sd_mosi", spi.SD_MOSI, 0);
        chk("rst_sd_cs", spi.SD_CS, 1);
        chk("rst_vsd_ss", spi.vsd_ss, 1);
        chk("rst_vsd_sck", spi.vsd_sck, 0);
        chk("rst_vsd_mosi", spi.vsd_mosi, 1);

        // Mount with sdss high from reset: SWITCH after 65 edges, route flips after 66.
        reset       = 1'b0;
        img_mounted = 1'b1;
        img_size    = 32'h0020_0000;
        tick(1);
        img_mounted = 1'b0;
        chk("mnt_busy", busy, 1);
        chk("mnt_sel_early", vsd_sel, 0);
        tick(63);
        chk("mnt_sel_wait", vsd_sel, 0);
        chk("mnt_sd_sck_wait", spi.SD_SCK, 1);
        tick(1);
        chk("sw_sel", vsd_sel, 0);
        chk("sw_busy", busy, 1);
        chk("sw_sd_cs", spi.SD_CS, 1);
        chk("sw_vsd_ss", spi.vsd_ss, 1);
        chk("sw_sd_sck", spi.SD_SCK, 0);
        chk("sw_vsd_sck", spi.vsd_sck, 0);
        chk("sw_sdmiso", spi.sdmiso, 1);
        tick(1);
        chk("post_sel", vsd_sel, 1);
        chk("post_busy", busy, 0);
        chk("post_vsd_sck", spi.vsd_sck, 1);
        chk("post_sd_sck", spi.SD_SCK, 0);

        // Unmount then remount two cycles later, bus active: request cancels without SWITCH.
        spi.sdss    = 1'b0;
        img_mounted = 1'b1;
        img_size    = 32'd0;
        tick(1);
        img_mounted = 1'b0;
        chk("cancel_busy0", busy, 1);
        tick(1);
        img_mounted = 1'b1;
        img_size    = 32'h0000_1000;
        tick(1);
        img_mounted = 1'b0;
        chk("cancel_pend_sel", dut.pend_sel, 1);
        chk("cancel_busy2", busy, 1);
        chk("cancel_vsd_ss", spi.vsd_ss, 0);
        tick(1);
        chk("cancel_busy3", busy, 0);
        chk("cancel_sel", vsd_sel, 1);

        // Virtual route: sdmiso tracks vsd_miso combinationally; physical card parked.
        spi.SD_MISO = 1'b0;
        spi.sdclk   = 1'b1;
        spi.sdmosi  = 1'b0;
        for (int i = 0; i < 4; i++) begin
            spi.vsd_miso = i[0];
            #1;
            chk("miso_follow", spi.sdmiso, {31'd0, i[0]});
            chk("miso_sd_cs", spi.SD_CS, 1);
            chk("miso_sd_sck", spi.SD_SCK, 0);
            chk("miso_sd_mosi", spi.SD_MOSI, 1);
            tick(1);
        end
        chk("miso_vsd_mosi", spi.vsd_mosi, 0);

        // LED: drain first, then 3 selected cycles -> lit for 3+16 cycles.
        spi.sdss = 1'b1;
        tick(20);
        chk("led_drained", drive_led, 0);
        for (int c = 0; c < 24; c++) begin
            spi.sdss = (c < 3) ? 1'b0 : 1'b1;
            #1;
            chk($sformatf("led_c%0d", c), drive_led, (c < 19) ? 1 : 0);
            tick(1);
        end

        // Reset in the middle of WAIT_IDLE abandons the change; simultaneous pulse dropped.
        reset = 1'b1;
        tick(1);
        reset       = 1'b0;
        spi.sdss    = 1'b0;
        img_mounted = 1'b1;
        img_size    = 32'h0000_0200;
        tick(1);
        img_mounted = 1'b0;
        tick(1);
        spi.sdss = 1'b1;
        tick(30);
        chk("midwait_busy", busy, 1);
        chk("midwait_idle", dut.idle_cnt, 30);
        reset       = 1'b1;
        img_mounted = 1'b1;
        tick(1);
        reset       = 1'b0;
        img_mounted = 1'b0;
        chk("rstwait_busy", busy, 0);
        chk("rstwait_sel", vsd_sel, 0);
        chk("rstwait_idle", dut.idle_cnt, 0);
        tick(1);
        chk("rstwait_pulse_dropped", busy, 0);
        chk("rstwait_sd_sck", spi.SD_SCK, 1);
        chk("rstwait_vsd_sck", spi.vsd_sck, 0);

        // Mount while the core is busy for 100 cycles: toggles reach SD_* only.
        spi.sdss    = 1'b0;
        img_mounted = 1'b1;
        img_size    = 32'h0000_0040;
        for (int c = 0; c < 100; c++) begin
            spi.sdclk  = c[0];
            spi.sdmosi = c[1];
            #1;
            if (c % 10 == 3) begin
                chk("act_sd_sck", spi.SD_SCK, {31'd0, c[0]});
                chk("act_sd_mosi", spi.SD_MOSI, {31'd0, c[1]});
                chk("act_vsd_sck", spi.vsd_sck, 0);
                chk("act_vsd_ss", spi.vsd_ss, 1);
                chk("act_sel", vsd_sel, 0);
            end
            tick(1);
            img_mounted = 1'b0;
        end
        chk("act_busy", busy, 1);
        spi.sdss  = 1'b1;
        spi.sdclk = 1'b0;
        tick(64);
        chk("idle64_sel", vsd_sel, 0);
        chk("idle64_busy", busy, 1);
        tick(1);
        chk("idle_sw_sd_cs", spi.SD_CS, 1);
        chk("idle_sw_sdmiso", spi.sdmiso, 1);
        chk("idle_sw_sel", vsd_sel, 0);
        tick(1);
        chk("idle_done_sel", vsd_sel, 1);
        chk("idle_done_busy", busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sd_spi_router.md
SD_SPI_ROUTER -- requirements
Module: sd_spi_router

Interface
REQ-001 SHALL have parameter IDLE_CYCLES, default 64, meaning consecutive deselected cycles (sdss high) required before a route change.
REQ-002 SHALL have parameter LED_HOLD, default 1048576, meaning clk_sys cycles drive_led stays on after the last access.
REQ-003 clk_sys  in  1  system clock; all logic on the rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 img_mounted  in  1  one-cycle pulse, image mount or unmount event.
REQ-006 img_size  in  32  image size in bytes, valid when img_mounted is 1.
REQ-007 sdss, sdclk, sdmosi  in  1 each  core-side SPI chip select (active low), clock and data.
REQ-008 sdmiso  out  1  core-side SPI data in.
REQ-009 vsd_ss, vsd_sck, vsd_mosi  out  1 each  SPI to the virtual SD card; vsd_miso  in  1.
REQ-010 SD_CS, SD_SCK, SD_MOSI  out  1 each  SPI to the physical SD card; SD_MISO  in  1.
REQ-011 vsd_sel  out  1  1 = virtual card routed, 0 = physical card routed.
REQ-012 busy  out  1  route change pending or in progress.
REQ-013 drive_led  out  1  card activity indicator, active high.

Function
REQ-014 SHALL implement the states RUN, WAIT_IDLE and SWITCH.
REQ-015 On an img_mounted pulse, SHALL capture pend_sel = (img_size != 0) and set pend.
- A later pulse while pend is set overwrites pend_sel; last event wins.
REQ-016 In RUN with pend set:
- pend_sel == vsd_sel: clear pend next cycle and stay in RUN.
- otherwise: go to WAIT_IDLE.
REQ-017 SHALL run an idle counter that:
- clears in any cycle with sdss low;
- increments while sdss is high;
- saturates at IDLE_CYCLES.
REQ-018 WAIT_IDLE -> SWITCH in the cycle after the idle counter reaches IDLE_CYCLES, with sdss still high.
- If sdss goes low during WAIT_IDLE, the counter restarts and the bus stays on the old route.
REQ-019 SWITCH SHALL last exactly one cycle, then:
- vsd_sel <= pend_sel;
- pend cleared;
- state returns to RUN.
REQ-020 An img_mounted pulse during WAIT_IDLE or SWITCH SHALL update pend_sel.
- If it arrives in the SWITCH cycle, pend stays set and a new evaluation happens in RUN.
REQ-021 Routing SHALL be combinational, zero latency, in RUN and WAIT_IDLE:
- selected card gets sdss/sdclk/sdmosi;
- sdmiso = selected card's MISO.
REQ-022 The unselected card, and both cards during SWITCH, SHALL be held idle: CS/ss = 1, SCK = 0, MOSI = 1.
- sdmiso = 1 during SWITCH.
REQ-023 busy SHALL be 1 when pend is set or state != RUN.
REQ-024 drive_led SHALL be 1 in any cycle sdss is low, and a hold counter loads LED_HOLD in that cycle.
- While sdss is high, the hold counter decrements toward 0 and drive_led = (counter != 0).
- The counter width is ceil(log2(LED_HOLD+1)).
REQ-025 The hold counter SHALL never wrap below 0.

Reset
REQ-026 With reset high at a clock edge, SHALL force:
- state RUN, vsd_sel 0, pend 0, pend_sel 0;
- idle counter 0, hold counter 0, drive_led 0, busy 0.
REQ-027 reset SHALL override a simultaneous img_mounted pulse; the pulse is discarded.
REQ-028 Reset during WAIT_IDLE or SWITCH SHALL abandon the change; the route returns to physical.
REQ-029 After reset, SD_* SHALL follow the core, and vsd_* SHALL be idle (ss 1, sck 0, mosi 1).

Verification
REQ-030 Scenario: reset, then mount pulse with img_size=0x200000, sdss held high -> busy=1, vsd_sel=1 after 64+2 cycles, and one SWITCH cycle with SD_CS=1 and vsd_ss=1.
REQ-031 Scenario: mount pulse while sdss is low for 100 cycles -> vsd_sel stays 0 until 64 idle cycles follow sdss rising; SPI toggles in that window reach SD_* only.
REQ-032 Scenario: vsd_sel=1, mount pulse img_size=0 then img_size=0x1000 two cycles later -> pend_sel=1, pend cleared without SWITCH, vsd_sel stays 1.
REQ-033 Scenario: reset asserted mid-WAIT_IDLE after 30 idle cycles -> next cycle busy=0, vsd_sel=0, idle counter 0.
REQ-034 Scenario: LED_HOLD=16, sdss low for 3 cycles then high -> drive_led=1 for exactly 3+16 cycles, then 0.
REQ-035 Scenario: vsd_sel=1, vsd_miso toggling, SD_MISO=0 -> sdmiso equals vsd_miso in the same cycle; SD_CS=1, SD_SCK=0, SD_MOSI=1 throughout.
